xadc_drp_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the XADC dynamic reconfiguration port (DRP). Shares the single read-only DRP between up to NUM_REQ requesters, e.g. the aux-channel sampler, an on-die temperature monitor and a supply-voltage monitor. It issues one `den` pulse per granted read, waits for `drdy` and captures `do`, then returns the result to the winning requester. A timeout ensures a missing `drdy` cannot hang the port. It sits between the XADC wizard instance and the ADC consumers; averaging and scaling remain downstream.

---
 rtl/xadc_pkg.sv | 20 ++
 rtl/xadc_drp_arbiter_if.sv | 23 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/xadc_drp_arbiter.sv | 154 +++++++++++++++
 tb/tb_xadc_drp_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/xadc_pkg.sv
// Shared definitions for the XADC DRP arbiter slice.
//   drp_state_t      - sequencer states (idle, issue den, wait drdy, respond)
//   ADDR_*           - commonly used XADC DRP register addresses
//   DEFAULT_TIMEOUT  - default drdy wait budget in clock cycles
package xadc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } drp_state_t;

  localparam logic [6:0] ADDR_TEMP   = 7'h00;
  localparam logic [6:0] ADDR_VCCINT = 7'h01;
  localparam logic [6:0] ADDR_VAUX15 = 7'h1F;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/xadc_drp_arbiter_if.sv
// XADC dynamic reconfiguration port bundle.
//   drp_den   - one-cycle read enable (master -> slave)
//   drp_daddr - register address (master -> slave)
//   drp_dwe   - write enable, always 0 from this arbiter (master -> slave)
//   drp_drdy  - data ready (slave -> master)
//   drp_do    - read data (slave -> master)
interface xadc_drp_arbiter_if;
  logic        drp_den;
  logic [6:0]  drp_daddr;
  logic        drp_dwe;
  logic        drp_drdy;
  logic [15:0] drp_do;

  modport master (
    output drp_den, drp_daddr, drp_dwe,
    input  drp_drdy, drp_do
  );

  modport slave (
    input  drp_den, drp_daddr, drp_dwe,
    output drp_drdy, drp_do
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr,
// searching upward and wrapping to 0.
//   req     - request vector
//   ptr     - search start index
//   valid   - any request present
//   gnt_oh  - one-hot winner
//   gnt_idx - binary index of winner
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic [31:0]      sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    valid   = 1'b0;
    gnt_oh  = '0;
    gnt_idx = '0;
    sum     = '0;
    cand    = '0;
    for (int unsigned ofs = 0; ofs < NUM_REQ; ofs++) begin
      sum = 32'(ptr) + ofs;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      cand = IDX_W'(sum);
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        gnt_oh[cand] = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/xadc_drp_arbiter.sv
// Round-robin arbiter/sequencer sharing one read-only XADC DRP between
// NUM_REQ requesters; one outstanding read at a time, drdy timeout.
//   clk, reset_n        - clock (also XADC dclk), async active-low reset
//   req, req_addr       - per-requester level request and 7-bit address
//   gnt                 - one-hot owner of the current transaction
//   rsp_valid           - one-cycle completion pulse to the owner
//   rsp_data, rsp_err   - read data / timeout flag, held until next response
//   drp                 - DRP master port
//   timeout_cnt         - saturating count of timed-out reads
module xadc_drp_arbiter
  import xadc_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [7*NUM_REQ-1:0] req_addr,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [15:0]          rsp_data,
  output logic                 rsp_err,
  xadc_drp_arbiter_if.master   drp,
  output logic [7:0]           timeout_cnt
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  drp_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [6:0]         daddr_q, daddr_d;
  logic               den_q, den_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [15:0]        rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic [15:0]        timer_q, timer_d;
  logic [7:0]         tcnt_q, tcnt_d;

  logic               arb_valid;
  logic [NUM_REQ-1:0] arb_oh;
  logic [IDX_W-1:0]   arb_idx;
  logic [6:0]         addr_arr [NUM_REQ];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req     (req),
    .ptr     (rr_ptr_q),
    .valid   (arb_valid),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr[7*i +: 7];
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    idx_d       = idx_q;
    rr_ptr_d    = rr_ptr_q;
    daddr_d     = daddr_q;
    den_d       = 1'b0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    timer_d     = timer_q;
    tcnt_d      = tcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        // den is registered here so it is high during the ISSUE cycle
        if (arb_valid) begin
          gnt_d   = arb_oh;
          idx_d   = arb_idx;
          daddr_d = addr_arr[arb_idx];
          den_d   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = 16'(TIMEOUT);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // drdy takes priority over an expiring timer in the same cycle
        if (drp.drp_drdy) begin
          rsp_data_d  = drp.drp_do;
          rsp_err_d   = 1'b0;
          rsp_valid_d = gnt_q;
          state_d     = ST_RESP;
        end else if (timer_q == '0) begin
          rsp_data_d  = 16'hFFFF;
          rsp_err_d   = 1'b1;
          rsp_valid_d = gnt_q;
          tcnt_d      = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
          state_d     = ST_RESP;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_RESP: begin
        rr_ptr_d = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        gnt_d    = '0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      idx_q       <= '0;
      rr_ptr_q    <= '0;
      daddr_q     <= '0;
      den_q       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      timer_q     <= '0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      idx_q       <= idx_d;
      rr_ptr_q    <= rr_ptr_d;
      daddr_q     <= daddr_d;
      den_q       <= den_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      timer_q     <= timer_d;
      tcnt_q      <= tcnt_d;
    end
  end

  assign gnt           = gnt_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;
  assign timeout_cnt   = tcnt_q;
  assign drp.drp_den   = den_q;
  assign drp.drp_daddr = daddr_q;
  assign drp.drp_dwe   = 1'b0;

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// Randomized bench for xadc_drp_arbiter (NUM_REQ=4, TIMEOUT=10) against a
// transaction-level timing model: requesters raise/withdraw requests, a DRP
// responder answers after a random delay or never, stray drdy pulses are
// injected outside the wait window, and one reset is applied mid-read.
module tb_xadc_drp_arbiter;
  import xadc_pkg::*;

  localparam int NREQ = 4;
  localparam int TMO  = 10;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NREQ-1:0]  req;
  logic [7*NREQ-1:0] req_addr;
  logic [NREQ-1:0]  gnt;
  logic [NREQ-1:0]  rsp_valid;
  logic [15:0]      rsp_data;
  logic             rsp_err;
  logic [7:0]       timeout_cnt;

  xadc_drp_arbiter_if drp_if ();

  xadc_drp_arbiter #(
    .NUM_REQ (NREQ),
    .TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .req_addr    (req_addr),
    .gnt         (gnt),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .drp         (drp_if.master),
    .timeout_cnt (timeout_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return 0;
  endfunction

  // requester side
  logic [NREQ-1:0] req_v;
  logic [6:0]      addr_m [NREQ];
  logic            drdy_v;
  logic [15:0]     do_v;

  // model state
  bit          active;
  int          owner, den_c, rsp_c, drdy_c, free_c, ptr, m_tcnt, d;
  bit          tmo;
  logic [15:0] txn_data, m_data;
  logic        m_err;
  logic [6:0]  m_addr;
  logic [NREQ-1:0] exp_g, exp_rv;
  bit          did_reset, no_raise, force_tmo;

  task automatic apply_inputs();
    req = req_v;
    for (int i = 0; i < NREQ; i++) req_addr[7*i +: 7] = addr_m[i];
    drp_if.drp_drdy = drdy_v;
    drp_if.drp_do   = do_v;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_gnt"},  32'(gnt), 32'd0);
    chk({pfx, "_rv"},   32'(rsp_valid), 32'd0);
    chk({pfx, "_data"}, 32'(rsp_data), 32'd0);
    chk({pfx, "_err"},  32'(rsp_err), 32'd0);
    chk({pfx, "_den"},  32'(drp_if.drp_den), 32'd0);
    chk({pfx, "_addr"}, 32'(drp_if.drp_daddr), 32'd0);
    chk({pfx, "_tcnt"}, 32'(timeout_cnt), 32'd0);
  endtask

  initial begin
    reset_n = 1'b1;
    req_v = '0; drdy_v = 1'b0; do_v = '0;
    for (int i = 0; i < NREQ; i++) addr_m[i] = '0;
    apply_inputs();
    active = 0; free_c = 0; ptr = 0; m_tcnt = 0; m_data = '0; m_err = 1'b0; m_addr = '0;
    owner = 0; den_c = 0; rsp_c = 0; drdy_c = -1; tmo = 0; txn_data = '0;
    did_reset = 0; no_raise = 0;
    #2 reset_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("por");
    @(negedge clk);
    reset_n = 1'b1;

    while (cyc < 10000) begin
      @(negedge clk);
      cyc++;
      force_tmo = (cyc >= 4000) && (cyc < 8500);

      // expected outputs for this cycle
      if (active && cyc == rsp_c) begin
        if (tmo) begin
          m_data = 16'hFFFF; m_err = 1'b1;
          m_tcnt = (m_tcnt == 255) ? 255 : m_tcnt + 1;
        end else begin
          m_data = txn_data; m_err = 1'b0;
        end
      end
      exp_g  = (active && cyc >= den_c && cyc <= rsp_c) ? NREQ'(1 << owner) : '0;
      exp_rv = (active && cyc == rsp_c) ? NREQ'(1 << owner) : '0;
      chk("gnt", 32'(gnt), 32'(exp_g));
      chk("den", 32'(drp_if.drp_den), 32'(active && cyc == den_c));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("rsp_data", 32'(rsp_data), 32'(m_data));
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
      chk("timeout_cnt", 32'(timeout_cnt), 32'(m_tcnt));
      chk("dwe", 32'(drp_if.drp_dwe), 32'd0);
      if (active && cyc >= den_c && cyc <= rsp_c)
        chk("daddr", 32'(drp_if.drp_daddr), 32'(m_addr));
      if (active && cyc == rsp_c) begin
        ptr = (owner + 1) % NREQ;
        req_v[owner] = 1'b0;
        active = 0;
      end

      // asynchronous reset in the middle of a read
      if (!did_reset && cyc >= 8500 && active && cyc == den_c + 2 && rsp_c > cyc) begin
        reset_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        active = 0; ptr = 0; m_tcnt = 0; m_data = '0; m_err = 1'b0;
        req_v = 4'b1010; drdy_v = 1'b0;
        apply_inputs();
        repeat (2) begin
          @(negedge clk);
          cyc++;
          chk("arst_hold_rv",  32'(rsp_valid), 32'd0);
          chk("arst_hold_gnt", 32'(gnt), 32'd0);
          chk("arst_hold_den", 32'(drp_if.drp_den), 32'd0);
        end
        reset_n   = 1'b1;
        did_reset = 1;
        free_c    = cyc;
        no_raise  = 1;
      end

      // requester behaviour
      if (!no_raise) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!req_v[i] && !(active && owner == i) && $urandom_range(0, 2) == 0) begin
            req_v[i]  = 1'b1;
            addr_m[i] = 7'($urandom);
          end
        end
      end
      no_raise = 0;
      if (active && cyc > den_c && cyc < rsp_c && $urandom_range(0, 15) == 0)
        req_v[owner] = 1'b0;

      // DRP responder, including stray drdy outside the wait window
      if (active && cyc == drdy_c) begin
        drdy_v = 1'b1; do_v = txn_data;
      end else if ((!active || cyc == den_c) && $urandom_range(0, 7) == 0) begin
        drdy_v = 1'b1; do_v = 16'($urandom);
      end else begin
        drdy_v = 1'b0; do_v = 16'($urandom);
      end

      // new transaction when the arbiter is idle and someone asks
      if (!active && cyc >= free_c && req_v != '0) begin
        owner  = rr_pick(req_v, ptr);
        den_c  = cyc + 1;
        m_addr = addr_m[owner];
        if (force_tmo || $urandom_range(0, 3) == 0) begin
          tmo = 1; drdy_c = -1; rsp_c = den_c + TMO + 2;
        end else begin
          tmo = 0;
          d = ($urandom_range(0, 3) == 0) ? TMO + 1 : int'($urandom_range(1, TMO + 1));
          drdy_c = den_c + d;
          rsp_c  = drdy_c + 1;
          txn_data = 16'($urandom);
        end
        free_c = rsp_c + 1;
        active = 1;
      end

      apply_inputs();
    end

    if (!did_reset) chk("reset_applied", 32'(did_reset), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
